// File: rtl/sd_cmd_rsp_ctrl_pkg.sv
// Shared types, default sizes and CRC7 helper for the SD command-response controller.
// Optional CRC checking is selected by the SD_RSP_CRC7_EN macro.
package sd_cmd_rsp_ctrl_pkg;

  localparam int DEF_SHORT_LEN = 48;   // R1/R3/R6/R7
  localparam int DEF_LONG_LEN  = 136;  // R2
  localparam int DEF_NCR_MAX   = 64;
  localparam int DEF_CNT_W     = 8;

  // CRC7 covers the payload but not the CRC field itself nor the end bit;
  // R2 additionally excludes its 8-bit start/transmission/reserved prefix.
  localparam int CRC_TAIL_BITS = 8;
  localparam int LONG_SKIP_BITS = 8;

  localparam logic [6:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RECV,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic timeout;
    logic end_bit;
    logic crc;
  } err_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_rsp_ctrl_crc7.sv
// Serial MSB-first CRC7 accumulator; only instantiated when SD_RSP_CRC7_EN is defined.
module sd_cmd_rsp_ctrl_crc7
  import sd_cmd_rsp_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc7_step(crc_q, din_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_rsp_ctrl.sv
// Sequences the CMD-line deserializer for one SD response and reports end-bit/timeout status.
// Define SD_RSP_CRC7_EN to also check the response CRC7 (crc_err_o is otherwise tied low).
module sd_cmd_rsp_ctrl
  import sd_cmd_rsp_ctrl_pkg::*;
#(
  parameter int SHORT_LEN = DEF_SHORT_LEN,
  parameter int LONG_LEN  = DEF_LONG_LEN,
  parameter int NCR_MAX   = DEF_NCR_MAX,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic long_rsp_i,
  input  logic abort_i,
  input  logic cmd_in_i,
  output logic des_reset_o,
  output logic des_finish_o,
  output logic des_in_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_err_o,
  output logic end_err_o,
  output logic crc_err_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  err_t             err_q, err_d;
  logic             done_q, done_d;
  logic             des_in_q;
  logic             crc_mismatch;

  // NOTE: the reset branch lives inside the clocked block because reset is
  // synchronous; all state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      tmo_q     <= '0;
      bit_cnt_q <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      des_in_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      tmo_q     <= tmo_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      des_in_q  <= cmd_in_i;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    tmo_d     = tmo_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d     = long_rsp_i ? CNT_W'(LONG_LEN) : CNT_W'(SHORT_LEN);
          err_d     = '0;
          tmo_d     = '0;
          bit_cnt_d = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tmo_d = tmo_q + CNT_W'(1);
        if (!cmd_in_i) begin
          bit_cnt_d = CNT_W'(1);
          state_d   = ST_RECV;
        end else if (tmo_q == CNT_W'(NCR_MAX - 1)) begin
          err_d.timeout = 1'b1;
          done_d        = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_RECV: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        // des_in_q lags cmd_in by one clock, so on the final count it holds the end bit.
        if (bit_cnt_q == len_q) begin
          err_d.end_bit = ~des_in_q;
          err_d.crc     = crc_mismatch;
          bit_cnt_d     = '0;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        bit_cnt_d = CNT_W'(1);
        if (bit_cnt_q == CNT_W'(1)) begin
          bit_cnt_d = '0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      err_d   = err_q;
    end
  end

`ifdef SD_RSP_CRC7_EN
  logic             is_long_q;
  logic [6:0]       crc_calc;
  logic [6:0]       rx_crc_q;
  logic [CNT_W-1:0] crc_first;
  logic [CNT_W-1:0] crc_last;
  logic             crc_en;
  logic             rx_en;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      is_long_q <= 1'b0;
    end else if (state_q == ST_IDLE && start_i && !abort_i) begin
      is_long_q <= long_rsp_i;
    end
  end

  // bit_cnt_q == j while des_in_q carries response bit len-j.
  assign crc_first = is_long_q ? CNT_W'(LONG_SKIP_BITS + 1) : CNT_W'(1);
  assign crc_last  = len_q - CNT_W'(CRC_TAIL_BITS);
  assign crc_en    = (state_q == ST_RECV) && (bit_cnt_q >= crc_first) && (bit_cnt_q <= crc_last);
  assign rx_en     = (state_q == ST_RECV) && (bit_cnt_q > crc_last) && (bit_cnt_q < len_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_crc_q <= '0;
    end else if (rx_en) begin
      rx_crc_q <= {rx_crc_q[5:0], des_in_q};
    end
  end

  sd_cmd_rsp_ctrl_crc7 u_crc7 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (des_reset_o),
    .en_i    (crc_en),
    .din_i   (des_in_q),
    .crc_o   (crc_calc)
  );

  assign crc_mismatch = (crc_calc != rx_crc_q);
`else
  assign crc_mismatch = 1'b0;
`endif

  assign des_reset_o   = (state_q == ST_IDLE) || (state_q == ST_WAIT);
  assign des_finish_o  = (state_q == ST_HOLD);
  assign des_in_o      = des_in_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign timeout_err_o = err_q.timeout;
  assign end_err_o     = err_q.end_bit;
  assign crc_err_o     = err_q.crc;

endmodule

// File: tb/tb_sd_cmd_rsp_ctrl.sv
// Self-checking bench for sd_cmd_rsp_ctrl: directed table, corner sequences, randomized responses.
module tb_sd_cmd_rsp_ctrl;

`ifdef SD_RSP_CRC7_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, long_rsp, abort, cmd_in;
  logic des_reset, des_finish, des_in, busy, done, timeout_err, end_err, crc_err;

  int checks = 0;
  int errors = 0;

  sd_cmd_rsp_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .long_rsp_i    (long_rsp),
    .abort_i       (abort),
    .cmd_in_i      (cmd_in),
    .des_reset_o   (des_reset),
    .des_finish_o  (des_finish),
    .des_in_o      (des_in),
    .busy_o        (busy),
    .done_o        (done),
    .timeout_err_o (timeout_err),
    .end_err_o     (end_err),
    .crc_err_o     (crc_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] crc_ref(input logic [135:0] f, input int hi);
    logic [143:0] w;
    int n;
    w = '0;
    n = hi - 7;
    for (int i = 0; i < n; i++) w[n+6-i] = f[hi-i];
    for (int i = n + 6; i >= 7; i--) if (w[i]) w[i-:8] = w[i-:8] ^ 8'h89;
    return w[6:0];
  endfunction

  function automatic logic [135:0] make_frame(input bit lng, input bit end_bad, input int flip);
    logic [135:0] f;
    int len, hi;
    len = lng ? 136 : 48;
    hi  = lng ? 127 : 47;
    f   = '0;
    for (int b = 0; b < len; b++) f[b] = 1'($urandom_range(0, 1));
    f[len-1] = 1'b0;
    f[len-2] = 1'b0;
    f[7:1]   = crc_ref(f, hi);
    f[0]     = ~end_bad;
    if (flip >= 0) f[flip] = ~f[flip];
    return f;
  endfunction

  // Transaction-level prediction: cycle index of done after the start edge, plus flags.
  task automatic predict(input int delay, input bit lng, input logic [135:0] f,
                         output int done_m, output bit tmo, output bit e_end, output bit e_crc);
    int len;
    len = lng ? 136 : 48;
    if (delay < 1 || delay > 64) begin
      done_m = 64; tmo = 1'b1; e_end = 1'b0; e_crc = 1'b0;
    end else begin
      done_m = delay + len + 2;
      tmo    = 1'b0;
      e_end  = ~f[0];
      e_crc  = CRC_ON && (crc_ref(f, lng ? 127 : 47) != f[7:1]);
    end
  endtask

  // Loop index i drives the inputs for start edge + i; outputs checked are those
  // of cycle m = i-1 after the start edge. A behavioural deserializer collects des_in.
  task automatic run_txn(input int delay, input bit lng, input logic [135:0] f,
                         input int abort_at, input bit use_rst, input int stray_at,
                         input int exp_done, input bit exp_tmo, input bit exp_end, input bit exp_crc);
    int len, last_m, busy_end, m, recv_n, fin_n, j;
    logic [135:0] sr, mask;
    len      = lng ? 136 : 48;
    mask     = lng ? {136{1'b1}} : {88'b0, {48{1'b1}}};
    busy_end = (exp_done >= 0) ? exp_done : abort_at;
    last_m   = (exp_done >= 0) ? exp_done + 1 : abort_at + 8;
    sr = '0; recv_n = 0; fin_n = 0;
    for (int i = 0; i <= last_m + 1; i++) begin
      @(negedge clk);
      m = i - 1;
      if (m >= 0) begin
        if (!des_reset && !des_finish) begin
          sr = {sr[134:0], des_in};
          recv_n++;
        end
        if (des_finish) fin_n++;
        check("done", done, (m == exp_done));
        check("busy", busy, (m < busy_end));
        if (m == 0) check("flags_cleared", {timeout_err, end_err, crc_err}, 3'b000);
        if (m == exp_done) begin
          check("timeout_err", timeout_err, exp_tmo);
          check("end_err", end_err, exp_end);
          check("crc_err", crc_err, exp_crc);
          check("recv_cycles", recv_n, exp_tmo ? 0 : len);
          check("finish_cycles", fin_n, exp_tmo ? 0 : 2);
          if (!exp_tmo) check("des_frame", sr & mask, f & mask);
        end
        if (exp_done < 0 && m == abort_at) check("des_reset_after_abort", des_reset, 1'b1);
      end
      start    = (i == 0) || (i == stray_at);
      long_rsp = (i == 0) ? lng : 1'($urandom_range(0, 1));
      abort    = (i == abort_at) && !use_rst;
      reset    = (i == abort_at) && use_rst;
      j        = i - delay;
      cmd_in   = (delay > 0 && j >= 0 && j < len) ? f[len-1-j] : 1'b1;
    end
    if (exp_done < 0) check("flags_after_abort", {timeout_err, end_err, crc_err}, 3'b000);
    start = 1'b0; abort = 1'b0; reset = 1'b0; cmd_in = 1'b1; long_rsp = 1'b0;
  endtask

  typedef struct {
    int delay;
    bit lng;
    bit end_bad;
    int flip;
    int abort_at;
    bit use_rst;
    int exp_done;
    bit exp_tmo;
    bit exp_end;
    bit exp_crc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [135:0] f;
    int dly, ab, st, dm, be;
    bit lng, tmo, e_end, e_crc;

    vecs[0]  = '{5,  1'b0, 1'b0, -1,  -1, 1'b0, 55,  1'b0, 1'b0, 1'b0};    // short OK
    vecs[1]  = '{0,  1'b0, 1'b0, -1,  -1, 1'b0, 64,  1'b1, 1'b0, 1'b0};    // no start bit
    vecs[2]  = '{3,  1'b0, 1'b1, -1,  -1, 1'b0, 53,  1'b0, 1'b1, 1'b0};    // end bit 0
    vecs[3]  = '{7,  1'b0, 1'b0, 20,  -1, 1'b0, 57,  1'b0, 1'b0, CRC_ON};  // bit 20 flipped
    vecs[4]  = '{2,  1'b1, 1'b0, -1,  -1, 1'b0, 140, 1'b0, 1'b0, 1'b0};    // R2
    vecs[5]  = '{64, 1'b0, 1'b0, -1,  -1, 1'b0, 114, 1'b0, 1'b0, 1'b0};    // start bit on last WAIT clock
    vecs[6]  = '{65, 1'b0, 1'b0, -1,  -1, 1'b0, 64,  1'b1, 1'b0, 1'b0};    // one clock too late
    vecs[7]  = '{1,  1'b0, 1'b0, -1,  -1, 1'b0, 51,  1'b0, 1'b0, 1'b0};    // immediate start bit
    vecs[8]  = '{4,  1'b0, 1'b0, -1,  34, 1'b0, -1,  1'b0, 1'b0, 1'b0};    // abort mid-RECV
    vecs[9]  = '{4,  1'b0, 1'b0, -1,  34, 1'b1, -1,  1'b0, 1'b0, 1'b0};    // reset mid-RECV
    vecs[10] = '{10, 1'b1, 1'b1, 130, -1, 1'b0, 148, 1'b0, 1'b1, 1'b0};    // R2 prefix flip, end bit 0

    reset = 1'b1; start = 1'b0; long_rsp = 1'b0; abort = 1'b0; cmd_in = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_des_reset", des_reset, 1'b1);
    check("rst_des_finish", des_finish, 1'b0);
    check("rst_des_in", des_in, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_errs", {timeout_err, end_err, crc_err}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      f = make_frame(vecs[k].lng, vecs[k].end_bad, vecs[k].flip);
      run_txn(vecs[k].delay, vecs[k].lng, f, vecs[k].abort_at, vecs[k].use_rst, -1,
              vecs[k].exp_done, vecs[k].exp_tmo, vecs[k].exp_end, vecs[k].exp_crc);
    end

    // abort while idle, coincident with start: start is dropped and flags are kept.
    @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("idle_abort_busy", busy, 1'b0);
    check("idle_abort_end_err_kept", end_err, 1'b1);
    @(negedge clk);
    check("idle_abort_still_idle", busy, 1'b0);
    check("idle_abort_no_done", done, 1'b0);

    for (int n = 0; n < 40; n++) begin
      lng = ($urandom_range(0, 3) == 0);
      dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 70));
      f   = make_frame(lng, ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, lng ? 134 : 46)) : -1);
      predict(dly, lng, f, dm, tmo, e_end, e_crc);
      ab = -1;
      if ($urandom_range(0, 7) == 0) begin
        ab = int'($urandom_range(1, dm));
        dm = -1; tmo = 1'b0; e_end = 1'b0; e_crc = 1'b0;
      end
      be = (dm >= 0) ? dm : ab;
      st = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, be)) : -1;
      run_txn(dly, lng, f, ab, 1'b0, st, dm, tmo, e_end, e_crc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
